// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int unsigned             INSTR_W    = 32;
    localparam int unsigned             PC_STEP    = 4;
    localparam logic [INSTR_W-1:0]      HALT_INSTR = 32'h0;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register: sequential increment, redirect, word alignment
// and wrap to the instruction memory size.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      MEM_WORDS = 1024,
    parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] ADDR_MASK = XLEN'((MEM_WORDS * PC_STEP) - 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Next PC selection: init beats redirect beats advance.
    always_comb begin
        pc_d = pc_q;
        if (init) begin
            pc_d = RESET_PC & ADDR_MASK;
        end else if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00} & ADDR_MASK;
        end else if (advance) begin
            pc_d = (pc_q + XLEN'(PC_STEP)) & ADDR_MASK;
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: loader-owned memory after reset, then one
// fetch per cycle into a registered IF stage with stall/redirect/halt.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      MEM_WORDS = 1024,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    input  logic [XLEN-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_ready,
    input  logic               load_done,
    output logic [XLEN-1:0]    mem_addr,
    output logic               mem_we,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    state_e               state_q, state_d;
    logic                 if_valid_q, if_valid_d;
    logic [XLEN-1:0]      if_pc_q, if_pc_d;
    logic [INSTR_W-1:0]   if_instr_q, if_instr_d;
    logic                 halted_q, halted_d;
    logic [XLEN-1:0]      pc;
    logic                 pc_init, pc_adv, pc_redir;
    logic                 fetch_new, stall_cyc;
    logic                 unused_load_bits;

    assign unused_load_bits = ^load_addr[1:0];

    fetch_pc_reg #(
        .XLEN      (XLEN),
        .MEM_WORDS (MEM_WORDS),
        .RESET_PC  (RESET_PC)
    ) u_pc (
        .clk            (clk),
        .reset          (reset),
        .init           (pc_init),
        .advance        (pc_adv),
        .redirect_valid (pc_redir),
        .redirect_pc    (redirect_pc),
        .pc             (pc)
    );

    // FSM next state, IF stage next values and memory port drive.
    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        halted_d   = halted_q;
        load_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        mem_wdata  = '0;
        pc_init    = 1'b0;
        pc_adv     = 1'b0;
        pc_redir   = 1'b0;
        fetch_new  = 1'b0;
        stall_cyc  = 1'b0;
        case (state_q)
            LOAD: begin
                load_ready = 1'b1;
                mem_we     = load_valid;
                mem_addr   = {load_addr[XLEN-1:2], 2'b00};
                mem_wdata  = load_data;
                if_valid_d = 1'b0;
                if (load_done) begin
                    state_d = RUN;
                    pc_init = 1'b1;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_redir   = 1'b1;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_pc_d    = pc;
                    if_instr_d = mem_rdata;
                    if (mem_rdata == HALT_INSTR) begin
                        if_valid_d = 1'b0;
                        halted_d   = 1'b1;
                        state_d    = HALT;
                    end else begin
                        if_valid_d = 1'b1;
                        pc_adv     = 1'b1;
                        fetch_new  = 1'b1;
                    end
                end else begin
                    stall_cyc = 1'b1;
                end
            end
            HALT: begin
                if_valid_d = 1'b0;
            end
            default: state_d = LOAD;
        endcase
        // Memory port is quiet while reset is held so it shows reset values.
        if (reset) begin
            load_ready = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
        end
    end

    // State and IF stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            halted_q   <= halted_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign halted   = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    // Saturating fetch and stall event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (fetch_new && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (stall_cyc && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    logic unused_perf_events;
    assign unused_perf_events = fetch_new ^ stall_cyc;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboard of per-cycle IF stage
// expectations plus a second small-memory instance for PC wrap.
module tb_fetch_sequencer;

    localparam logic [31:0] W0 = 32'h00536823;
    localparam logic [31:0] W1 = 32'h00536833;
    localparam logic [31:0] W2 = 32'h00536803;
    localparam logic [31:0] W3 = 32'h00536863;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        h;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    // Main DUT signals
    logic        reset = 1'b1, load_valid = 1'b0, load_done = 1'b0;
    logic [31:0] load_addr = '0, load_data = '0;
    logic        stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        load_ready, mem_we, if_valid, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, if_pc, if_instr;
    logic [31:0] mem [1024] = '{default: '0};
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    fetch_sequencer #(.XLEN(32), .MEM_WORDS(1024), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Wrap DUT signals (4-word memory, preloaded directly)
    logic        w_reset = 1'b1, w_done = 1'b0;
    logic        w_load_ready, w_mem_we, w_if_valid, w_halted;
    logic [31:0] w_mem_addr, w_mem_wdata, w_mem_rdata, w_if_pc, w_if_instr;
    logic [31:0] wmem [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic        wrap_done = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] w_perf_fetch_cnt, w_perf_stall_cnt;
`endif

    assign w_mem_rdata = wmem[w_mem_addr[3:2]];

    fetch_sequencer #(.XLEN(32), .MEM_WORDS(4), .RESET_PC(32'h0)) dut_wrap (
        .clk(clk), .reset(w_reset),
        .load_valid(1'b0), .load_addr(32'h0), .load_data(32'h0),
        .load_ready(w_load_ready), .load_done(w_done),
        .mem_addr(w_mem_addr), .mem_we(w_mem_we), .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_instr(w_if_instr), .halted(w_halted)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_stall_cnt(w_perf_stall_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t E(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic h);
        exp_t e;
        e.v = v; e.pc = pc; e.ins = ins; e.h = h;
        return e;
    endfunction

    // Drive all main-DUT inputs for one cycle; optionally queue the IF state expected after the edge.
    task automatic cyc(input logic rst, input logic lv, input logic [31:0] la, input logic [31:0] ld,
                       input logic dn, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic psh, input exp_t e);
        @(negedge clk);
        reset = rst; load_valid = lv; load_addr = la; load_data = ld; load_done = dn;
        stall = st; redirect_valid = rv; redirect_pc = rpc;
        if (psh) sb.push_back(e);
    endtask

    task automatic step(input logic st, input logic rv, input logic [31:0] rpc, input exp_t e);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, st, rv, rpc, 1'b1, e);
    endtask

    // Monitor: after each edge, compare the IF stage against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_if_valid", {31'b0, if_valid}, {31'b0, e.v});
                chk("sb_halted", {31'b0, halted}, {31'b0, e.h});
                if (e.v) begin
                    chk("sb_if_pc", if_pc, e.pc);
                    chk("sb_if_instr", if_instr, e.ins);
                end
            end
        end
    end

    // Wrap instance: five fetches from a 4-word memory.
    initial begin
        logic [31:0] exp_pc [5];
        logic [31:0] exp_in [5];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
        exp_in = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h11111111};
        repeat (2) @(negedge clk);
        w_reset = 1'b0;
        w_done  = 1'b1;
        @(negedge clk);
        w_done  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("wrap_if_valid", {31'b0, w_if_valid}, 32'h1);
            chk("wrap_if_pc", w_if_pc, exp_pc[i]);
            chk("wrap_if_instr", w_if_instr, exp_in[i]);
        end
        wrap_done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: memory port quiet even with load_valid high
        cyc(1, 1, 32'h0, W0, 0, 0, 0, 32'h0, 0, E(0, 0, 0, 0));
        #1;
        chk("rst_load_ready", {31'b0, load_ready}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 1, E(0, 0, 0, 0));
        // Load (stall/redirect ignored in LOAD)
        cyc(0, 1, 32'h0, W0, 0, 1, 1, 32'h40, 1, E(0, 0, 0, 0));
        #1;
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("load_ready", {31'b0, load_ready}, 32'h1);
        chk("load_mem_we", {31'b0, mem_we}, 32'h1);
        chk("load_wdata", mem_wdata, W0);
        cyc(0, 1, 32'h5, W1, 0, 1, 1, 32'h40, 1, E(0, 0, 0, 0));
        #1;
        chk("load_addr_align", mem_addr, 32'h4);
        cyc(0, 1, 32'h8, W2, 0, 0, 0, 32'h0, 1, E(0, 0, 0, 0));
        cyc(0, 1, 32'hC, W3, 0, 0, 0, 32'h0, 1, E(0, 0, 0, 0));
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 1, E(0, 0, 0, 0));
        // Sequential fetch to halt
        step(0, 0, 32'h0, E(1, 32'h0, W0, 0));
        step(0, 0, 32'h0, E(1, 32'h4, W1, 0));
        step(0, 0, 32'h0, E(1, 32'h8, W2, 0));
        step(0, 0, 32'h0, E(1, 32'hC, W3, 0));
        step(0, 0, 32'h0, E(0, 32'h0, 32'h0, 1));
        // HALT ignores redirect, loads and load_done
        cyc(0, 1, 32'h0, 32'hFFFFFFFF, 1, 0, 1, 32'h0, 1, E(0, 0, 0, 1));
        #1;
        chk("halt_load_ready", {31'b0, load_ready}, 32'h0);
        chk("halt_mem_we", {31'b0, mem_we}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_s1", perf_fetch_cnt, 32'd4);
        chk("perf_stall_s1", perf_stall_cnt, 32'd0);
`endif
        // Reset and rerun from preserved memory
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 1, E(0, 0, 0, 0));
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 1, E(0, 0, 0, 0));
`ifdef FETCH_PERF_CNT_EN
        #1;
        chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
`endif
        step(0, 0, 32'h0, E(1, 32'h0, W0, 0));
        step(0, 0, 32'h0, E(1, 32'h4, W1, 0));
        // Stall three cycles at if_pc=4
        repeat (3) step(1, 0, 32'h0, E(1, 32'h4, W1, 0));
        step(0, 0, 32'h0, E(1, 32'h8, W2, 0));
        // Load attempt in RUN (with stall) must be ignored
        cyc(0, 1, 32'h0, 32'hFFFFFFFF, 0, 1, 0, 32'h0, 1, E(1, 32'h8, W2, 0));
        #1;
        chk("run_load_ready", {31'b0, load_ready}, 32'h0);
        chk("run_mem_we", {31'b0, mem_we}, 32'h0);
        // Redirect beats stall; unaligned target 0xE -> 0xC
        step(1, 1, 32'hE, E(0, 0, 0, 0));
        step(0, 0, 32'h0, E(1, 32'hC, W3, 0));
`ifdef FETCH_PERF_CNT_EN
        #1;
        chk("perf_stall_cnt", perf_stall_cnt, 32'd4);
`endif
        // Redirect to 0 still finds the original word
        step(0, 1, 32'h0, E(0, 0, 0, 0));
        step(0, 0, 32'h0, E(1, 32'h0, W0, 0));
        step(0, 0, 32'h0, E(1, 32'h4, W1, 0));
        step(0, 0, 32'h0, E(1, 32'h8, W2, 0));
        // Reset mid-run at if_pc=8
        cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 1, E(0, 0, 0, 0));
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, E(0, 0, 0, 0));
        #1;
        chk("midrst_load_ready", {31'b0, load_ready}, 32'h1);
        chk("midrst_if_pc", if_pc, 32'h0);
        chk("midrst_halted", {31'b0, halted}, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 1, E(0, 0, 0, 0));
        step(0, 0, 32'h0, E(1, 32'h0, W0, 0));
        step(0, 0, 32'h0, E(1, 32'h4, W1, 0));
        step(0, 0, 32'h0, E(1, 32'h8, W2, 0));
        step(0, 0, 32'h0, E(1, 32'hC, W3, 0));
        step(0, 0, 32'h0, E(0, 0, 0, 1));
        step(1, 1, 32'h4, E(0, 0, 0, 1));
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, E(0, 0, 0, 0));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 100 && !wrap_done; i++) @(negedge clk);
        if (!wrap_done) begin
            tests++;
            fails++;
            $display("FAIL wrap_timeout: got not-done expected done");
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
